uart_cmd_responder: RTL and testbench

Module-side endpoint of the main-to-module command link. It takes decoded bytes from the local `uart_rx` and interprets the command set: turn-on `8'hEE`, turn-off `8'h55`, toggle `8'hC3`. It drives the module's output-enable flag and echoes every accepted command back through the local `uart_tx`, which lets the main board verify the round trip. Unknown or corrupted bytes get a NAK. A watchdog forces the output off if the link goes silent.

---
 rtl/uart_cmd_responder.sv | 165 ++++++++++++++++
 tb/tb_uart_cmd_responder.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_responder.sv
`default_nettype none
// ============================================================================
// Module : uart_cmd_responder
// Decodes link command bytes, drives out_en, echoes or NAKs via uart_tx.
// Rev    : 1.0
// ============================================================================
module uart_cmd_responder #(
  parameter logic [7:0]  CMD_ON         = 8'hEE,
  parameter logic [7:0]  CMD_OFF        = 8'h55,
  parameter logic [7:0]  CMD_TOGGLE     = 8'hC3,
  parameter logic [7:0]  NAK            = 8'h00,
  parameter int unsigned TIMEOUT_CYCLES = 48000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_done,
  input  logic [7:0] data_received,
  input  logic       parity_error,
  input  logic       tx_busy,
  output logic       start_tx,
  output logic [7:0] data_to_tx,
  output logic       out_en,
  output logic       link_ok,
  output logic       cmd_err
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_SEND      = 2'd1;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] WD_ARM  = 32'(TIMEOUT_CYCLES - 2);

  logic [1:0]  state_q, state_d;
  logic [7:0]  cur_q, cur_d;
  logic [7:0]  pend_q, pend_d;
  logic        pend_vld_q, pend_vld_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        out_en_q, out_en_d;
  logic        link_ok_q, link_ok_d;
  logic        cmd_err_q, cmd_err_d;
  logic [31:0] wd_cnt_q, wd_cnt_d;

  logic       w_is_cmd;
  logic       w_valid;
  logic       w_drop;
  logic       w_direct;
  logic       w_store;
  logic       w_load_slot;
  logic       w_expire;
  logic [7:0] w_reply;

  always_comb begin
    w_is_cmd    = !parity_error && ((data_received == CMD_ON) ||
                                    (data_received == CMD_OFF) ||
                                    (data_received == CMD_TOGGLE));
    w_valid     = rx_done && w_is_cmd;
    w_reply     = w_is_cmd ? data_received : NAK;
    w_drop      = rx_done && pend_vld_q;
    w_direct    = rx_done && !pend_vld_q && (state_q == ST_IDLE);
    w_store     = rx_done && !pend_vld_q && (state_q != ST_IDLE);
    w_load_slot = pend_vld_q && ((state_q == ST_IDLE) ||
                                 ((state_q == ST_WAIT_DONE) && !tx_busy));
    // Expiry is decided one cycle early so out_en drops exactly on timeout.
    w_expire    = (wd_cnt_q >= WD_ARM);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (pend_vld_q || rx_done) state_d = ST_SEND;
      ST_SEND:      if (!tx_busy) state_d = ST_WAIT_BUSY;
      ST_WAIT_BUSY: if (tx_busy) state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: if (!tx_busy) state_d = pend_vld_q ? ST_SEND : ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // data_to_tx shows the new byte in the start_tx cycle and holds it after.
  always_comb begin
    start_tx   = (state_q == ST_SEND) && !tx_busy;
    data_to_tx = start_tx ? cur_q : tx_data_q;
    out_en     = out_en_q;
    link_ok    = link_ok_q;
    cmd_err    = cmd_err_q;
  end

  always_comb begin
    cur_d      = cur_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    tx_data_d  = start_tx ? cur_q : tx_data_q;
    out_en_d   = out_en_q;
    link_ok_d  = link_ok_q;
    cmd_err_d  = (rx_done && !w_is_cmd) || w_drop;

    if (w_load_slot) begin
      cur_d      = pend_q;
      pend_vld_d = 1'b0;
    end else if (w_direct) begin
      cur_d = w_reply;
    end
    if (w_store) begin
      pend_d     = w_reply;
      pend_vld_d = 1'b1;
    end

    if (w_expire) begin
      out_en_d  = 1'b0;
      link_ok_d = 1'b0;
    end
    // A valid command overrides a coincident expiry; toggle uses the old value.
    if (w_valid) begin
      link_ok_d = 1'b1;
      if (data_received == CMD_ON) begin
        out_en_d = 1'b1;
      end else if (data_received == CMD_OFF) begin
        out_en_d = 1'b0;
      end else begin
        out_en_d = !out_en_q;
      end
    end

    if (w_valid) begin
      wd_cnt_d = 32'd0;
    end else if (wd_cnt_q < WD_LAST) begin
      wd_cnt_d = wd_cnt_q + 32'd1;
    end else begin
      wd_cnt_d = wd_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cur_q      <= 8'd0;
      pend_q     <= 8'd0;
      pend_vld_q <= 1'b0;
      tx_data_q  <= 8'd0;
      out_en_q   <= 1'b0;
      link_ok_q  <= 1'b0;
      cmd_err_q  <= 1'b0;
      wd_cnt_q   <= 32'd0;
    end else begin
      cur_q      <= cur_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      tx_data_q  <= tx_data_d;
      out_en_q   <= out_en_d;
      link_ok_q  <= link_ok_d;
      cmd_err_q  <= cmd_err_d;
      wd_cnt_q   <= wd_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_responder.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_cmd_responder
// Self-checking bench for uart_cmd_responder with a behavioural link model.
// Rev    : 1.0
// ============================================================================
module tb_uart_cmd_responder;

  localparam int T = 100;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx_done = 1'b0;
  logic [7:0] data_received = 8'h00;
  logic       parity_error = 1'b0;
  logic       tx_busy = 1'b0;
  logic       start_tx;
  logic [7:0] data_to_tx;
  logic       out_en;
  logic       link_ok;
  logic       cmd_err;

  uart_cmd_responder #(.TIMEOUT_CYCLES(T)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .rx_done       (rx_done),
    .data_received (data_received),
    .parity_error  (parity_error),
    .tx_busy       (tx_busy),
    .start_tx      (start_tx),
    .data_to_tx    (data_to_tx),
    .out_en        (out_en),
    .link_ok       (link_ok),
    .cmd_err       (cmd_err)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  int         cyc = 0;
  int         last_valid = 0;
  bit         have_valid;
  bit         m_out_en, m_link, m_err;
  logic [7:0] exp_q[$];
  int         outstanding;
  bit         in_tx, saw_busy;
  int         starts = 0;
  logic [7:0] last_sent;
  int         busy_cnt, busy_len = 10;
  bit         auto_busy, rand_len;

  typedef struct {
    logic [7:0] d;
    bit         pe;
    bit         en;
    bit         err;
    logic [7:0] reply;
  } vec_t;
  vec_t tbl[10];

  int s0, gap, sel;
  logic [7:0] rd;
  bit rpe;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_reset();
    have_valid = 0; m_out_en = 0; m_link = 0; m_err = 0;
    exp_q.delete(); outstanding = 0; in_tx = 0; saw_busy = 0;
    last_sent = 8'h00; busy_cnt = 0;
  endtask

  task automatic cycle(input bit rxd, input logic [7:0] d, input bit pe);
    bit is_cmd, nerr, frame_end;
    rx_done = rxd; data_received = d; parity_error = pe;
    if (auto_busy) tx_busy = (busy_cnt > 0);
    #1;
    chk("out_en", out_en, m_out_en);
    chk("link_ok", link_ok, m_link);
    chk("cmd_err", cmd_err, m_err);
    frame_end = in_tx && saw_busy && !tx_busy;
    if (in_tx && tx_busy) saw_busy = 1;
    if (frame_end) in_tx = 0;
    if (start_tx) begin
      chk("start_while_busy", tx_busy, 1'b0);
      if (exp_q.size() == 0) chk("spurious_start_tx", start_tx, 1'b0);
      else chk("reply_byte", data_to_tx, exp_q.pop_front());
      starts++; last_sent = data_to_tx; in_tx = 1; saw_busy = 0;
      if (rand_len) busy_len = $urandom_range(1, 12);
      busy_cnt = busy_len;
    end else begin
      chk("data_hold", data_to_tx, last_sent);
      if (busy_cnt > 0) busy_cnt--;
    end
    // Decode: at most one reply in flight plus one waiting.
    is_cmd = !pe && (d == 8'hEE || d == 8'h55 || d == 8'hC3);
    nerr = 0;
    if (rxd) begin
      if (!is_cmd) nerr = 1;
      if (outstanding >= 2) nerr = 1;
      else begin
        exp_q.push_back(is_cmd ? d : 8'h00);
        outstanding++;
      end
    end
    if (frame_end) outstanding--;
    if (rxd && is_cmd) begin
      case (d)
        8'hEE:   m_out_en = 1;
        8'h55:   m_out_en = 0;
        default: m_out_en = !m_out_en;
      endcase
      m_link = 1; have_valid = 1; last_valid = cyc;
    end else if (have_valid && (cyc + 1 - last_valid) >= T) begin
      m_out_en = 0; m_link = 0;
    end
    m_err = nerr;
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    reset_n = 0; rx_done = 0; parity_error = 0; data_received = 8'h00;
    @(posedge clk); #1;
    reset_n = 1;
    cyc++;
    model_reset();
    chk("rst_start_tx", start_tx, 1'b0);
    chk("rst_data_to_tx", data_to_tx, 8'h00);
    chk("rst_out_en", out_en, 1'b0);
    chk("rst_link_ok", link_ok, 1'b0);
    chk("rst_cmd_err", cmd_err, 1'b0);
  endtask

  task automatic drain(input int max);
    int i;
    i = 0;
    while (outstanding != 0 && i < max) begin
      cycle(1'b0, 8'h00, 1'b0);
      i++;
    end
    chk("drain_timeout", outstanding, 0);
  endtask

  initial begin
    #600000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{8'hEE, 1'b0, 1'b1, 1'b0, 8'hEE};
    tbl[1] = '{8'hC3, 1'b0, 1'b0, 1'b0, 8'hC3};
    tbl[2] = '{8'hC3, 1'b0, 1'b1, 1'b0, 8'hC3};
    tbl[3] = '{8'h12, 1'b0, 1'b1, 1'b1, 8'h00};
    tbl[4] = '{8'h55, 1'b1, 1'b1, 1'b1, 8'h00};
    tbl[5] = '{8'h55, 1'b0, 1'b0, 1'b0, 8'h55};
    tbl[6] = '{8'hC3, 1'b1, 1'b0, 1'b1, 8'h00};
    tbl[7] = '{8'hFF, 1'b0, 1'b0, 1'b1, 8'h00};
    tbl[8] = '{8'hEE, 1'b1, 1'b0, 1'b1, 8'h00};
    tbl[9] = '{8'hC3, 1'b0, 1'b1, 1'b0, 8'hC3};

    auto_busy = 1; rand_len = 0; busy_len = 10;
    model_reset();
    apply_reset();

    // First command: echo requested on the very next cycle.
    cycle(1'b1, 8'hEE, 1'b0);
    chk("first_start_tx", start_tx, 1'b1);
    chk("first_data_to_tx", data_to_tx, 8'hEE);
    chk("first_out_en", out_en, 1'b1);
    chk("first_link_ok", link_ok, 1'b1);
    drain(40);

    apply_reset();
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, tbl[i].d, tbl[i].pe);
      chk($sformatf("vec%0d_out_en", i), out_en, tbl[i].en);
      chk($sformatf("vec%0d_cmd_err", i), cmd_err, tbl[i].err);
      s0 = starts;
      drain(60);
      chk($sformatf("vec%0d_echo_count", i), starts, s0 + 1);
      chk($sformatf("vec%0d_echo_byte", i), last_sent, tbl[i].reply);
    end

    // Three commands while uart_tx stays busy: one sending, one waiting, one dropped.
    auto_busy = 0;
    apply_reset();
    tx_busy = 1;
    s0 = starts;
    cycle(1'b1, 8'hC3, 1'b0);
    chk("hold_out_en_1", out_en, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b1, 8'h55, 1'b0);
    chk("hold_out_en_2", out_en, 1'b0);
    chk("hold_cmd_err_2", cmd_err, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b1, 8'hEE, 1'b0);
    chk("hold_out_en_3", out_en, 1'b1);
    chk("hold_cmd_err_3", cmd_err, 1'b1);
    repeat (5) cycle(1'b0, 8'h00, 1'b0);
    chk("hold_no_start", starts, s0);
    auto_busy = 1; busy_len = 10;
    drain(80);
    chk("hold_two_starts", starts, s0 + 2);

    // Watchdog expiry exactly T cycles after the last valid command.
    apply_reset();
    cycle(1'b1, 8'hEE, 1'b0);
    repeat (98) cycle(1'b0, 8'h00, 1'b0);
    chk("wd_pre_out_en", out_en, 1'b1);
    chk("wd_pre_link_ok", link_ok, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
    chk("wd_exp_out_en", out_en, 1'b0);
    chk("wd_exp_link_ok", link_ok, 1'b0);

    // Commands coinciding with expiry win; toggle uses the pre-expiry value.
    apply_reset();
    cycle(1'b1, 8'hEE, 1'b0);
    repeat (98) cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b1, 8'hEE, 1'b0);
    chk("wd_on_out_en", out_en, 1'b1);
    chk("wd_on_link_ok", link_ok, 1'b1);
    repeat (98) cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b1, 8'hC3, 1'b0);
    chk("wd_tog_out_en", out_en, 1'b0);
    chk("wd_tog_link_ok", link_ok, 1'b1);
    drain(40);

    // Reset while waiting for tx_busy to rise.
    auto_busy = 0; tx_busy = 0;
    apply_reset();
    s0 = starts;
    cycle(1'b1, 8'hEE, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    chk("mid_started", starts, s0 + 1);
    apply_reset();
    tx_busy = 1;
    repeat (8) cycle(1'b0, 8'h00, 1'b0);
    tx_busy = 0;
    repeat (20) cycle(1'b0, 8'h00, 1'b0);
    chk("mid_no_restart", starts, s0 + 1);

    // Randomised traffic against the model.
    auto_busy = 1; rand_len = 1;
    apply_reset();
    for (int k = 0; k < 150; k++) begin
      sel = $urandom_range(0, 4);
      case (sel)
        0:       rd = 8'hEE;
        1:       rd = 8'h55;
        2, 4:    rd = 8'hC3;
        default: rd = 8'($urandom_range(0, 255));
      endcase
      rpe = ($urandom_range(0, 7) == 0);
      cycle(1'b1, rd, rpe);
      gap = ($urandom_range(0, 11) == 0) ? $urandom_range(96, 101) : $urandom_range(1, 14);
      repeat (gap) cycle(1'b0, 8'h00, 1'b0);
    end
    drain(200);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
